// File: rtl/mult_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_pkg
// Description : Shared types and helpers for the multiplier arbiter slice.
// Revision    : 1.0 - initial release
// ============================================================================
package mult_arbiter_pkg;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ARB_IDLE  = 3'd0,
        ARB_START = 3'd1,
        ARB_WAIT  = 3'd2,
        ARB_DONE  = 3'd3,
        ARB_DRAIN = 3'd4
    } estado_arb_t;

    // States of the shared shift-add multiplier
    typedef enum logic [1:0] {
        MULT_IDLE = 2'd0,
        MULT_RUN  = 2'd1,
        MULT_FIM  = 2'd2
    } estado_mult_t;

    // Round-robin successor of idx within 0..n-1
    function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
        return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter_if
// Description : Requester-side bus of the multiplier arbiter (requests,
//               operands, grant, result valid and product).
// Revision    : 1.0 - initial release
// ============================================================================
interface mult_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int W_OP  = 4
);
    logic [N_REQ-1:0]      req_i;
    logic [N_REQ*W_OP-1:0] a_i;
    logic [N_REQ*W_OP-1:0] b_i;
    logic [N_REQ-1:0]      gnt_o;
    logic [N_REQ-1:0]      vld_o;
    logic [2*W_OP-1:0]     y_o;

    // Processing units drive requests and operands
    modport master (
        output req_i, a_i, b_i,
        input  gnt_o, vld_o, y_o
    );

    // Arbiter receives requests and returns grant/result
    modport slave (
        input  req_i, a_i, b_i,
        output gnt_o, vld_o, y_o
    );
endinterface
`default_nettype wire

// File: rtl/mult_arbiter_rr_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_picker
// Description : Combinational round-robin picker. Scans requests starting at
//               ptr and returns the first hit as one-hot and as an index.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_picker #(
    parameter int N_REQ = 4,
    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  wire  [N_REQ-1:0] req_i,
    input  wire  [PTR_W-1:0] ptr_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] idx_o
);

    logic             found;
    logic [PTR_W-1:0] pos;

    // Scan ptr, ptr+1, ... wrapping at N_REQ; first requester seen wins
    always_comb begin
        found = 1'b0;
        gnt_o = '0;
        idx_o = '0;
        pos   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            pos = PTR_W'((int'(ptr_i) + k) % N_REQ);
            if (!found && req_i[pos]) begin
                found      = 1'b1;
                gnt_o[pos] = 1'b1;
                idx_o      = pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mult_arbiter
// Description : Round-robin scheduler sharing one shift-add multiplier among
//               N_REQ requesters. Latches the winner's operands, runs the
//               start/done handshake and returns the product with a one-cycle
//               valid pulse. Performs no arithmetic itself.
// Revision    : 1.0 - initial release
// ============================================================================
module mult_arbiter
    import mult_arbiter_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int W_OP  = 4
) (
    input  wire                 clk_i,
    input  wire                 rst_i,
    mult_arbiter_if.slave       bus,
    output logic                busy_o,
    output logic                mult_en_o,
    output logic [W_OP-1:0]     mult_a_o,
    output logic [W_OP-1:0]     mult_b_o,
    input  wire  [2*W_OP-1:0]   mult_y_i,
    input  wire                 mult_fim_i
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    estado_arb_t        state_q;
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   win_idx;
    logic [N_REQ-1:0]   win_oh;
    logic [N_REQ-1:0]   gnt_q;
    logic [N_REQ-1:0]   vld_q;
    logic [W_OP-1:0]    a_q;
    logic [W_OP-1:0]    b_q;
    logic [2*W_OP-1:0]  y_q;
    logic               busy_q;
    logic               en_q;

    logic [W_OP-1:0]    a_arr [N_REQ];
    logic [W_OP-1:0]    b_arr [N_REQ];

    // Split the packed operand buses into per-requester slices
    generate
        for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
            assign a_arr[k] = bus.a_i[k*W_OP +: W_OP];
            assign b_arr[k] = bus.b_i[k*W_OP +: W_OP];
        end
    endgenerate

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req_i (bus.req_i),
        .ptr_i (ptr_q),
        .gnt_o (win_oh),
        .idx_o (win_idx)
    );

    assign ptr_d = PTR_W'(rr_next(32'(win_idx), N_REQ));

    // Sequencer: grant/latch in IDLE, drive multiplier, deliver result, drain
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ARB_IDLE;
            ptr_q   <= '0;
            gnt_q   <= '0;
            vld_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            y_q     <= '0;
            busy_q  <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            vld_q <= '0;
            case (state_q)
                ARB_IDLE: begin
                    if (|bus.req_i) begin
                        state_q <= ARB_START;
                        gnt_q   <= win_oh;
                        a_q     <= a_arr[win_idx];
                        b_q     <= b_arr[win_idx];
                        ptr_q   <= ptr_d;
                        busy_q  <= 1'b1;
                        en_q    <= 1'b1;
                    end
                end
                // Done flag is not looked at here: a stale level from the
                // previous run must not end this one early
                ARB_START: begin
                    state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (mult_fim_i) begin
                        state_q <= ARB_DONE;
                        y_q     <= mult_y_i;
                        vld_q   <= gnt_q;
                        en_q    <= 1'b0;
                    end
                end
                ARB_DONE: begin
                    gnt_q <= '0;
                    if (mult_fim_i) begin
                        state_q <= ARB_DRAIN;
                    end else begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                // Hold off new starts until a level-type done flag falls
                ARB_DRAIN: begin
                    if (!mult_fim_i) begin
                        state_q <= ARB_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ARB_IDLE;
                    gnt_q   <= '0;
                    busy_q  <= 1'b0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt_o = gnt_q;
    assign bus.vld_o = vld_q;
    assign bus.y_o   = y_q;
    assign busy_o    = busy_q;
    assign mult_en_o = en_q;
    assign mult_a_o  = a_q;
    assign mult_b_o  = b_q;

endmodule
`default_nettype wire

// File: tb/tb_mult_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mult_arbiter
// Description : Self-checking bench for mult_arbiter with a behavioural
//               multiplier of configurable latency and done-hold length.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_arbiter;

    localparam int N_REQ = 4;
    localparam int W_OP  = 4;

    logic       clk;
    logic       rst;
    logic       busy;
    logic       mult_en;
    logic [3:0] mult_a;
    logic [3:0] mult_b;
    logic [7:0] mult_y;
    logic       mult_fim;
    logic       fim_m;
    logic       fim_force;
    logic [7:0] y_m;

    int total = 0;
    int bad   = 0;
    int lat   = 5;
    int hold  = 1;

    mult_arbiter_if #(.N_REQ(N_REQ), .W_OP(W_OP)) bus ();

    mult_arbiter #(.N_REQ(N_REQ), .W_OP(W_OP)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .bus        (bus),
        .busy_o     (busy),
        .mult_en_o  (mult_en),
        .mult_a_o   (mult_a),
        .mult_b_o   (mult_b),
        .mult_y_i   (mult_y),
        .mult_fim_i (mult_fim)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mult_fim = fim_m | fim_force;
    assign mult_y   = y_m;

    // Behavioural multiplier: done rises lat cycles after start, stays hold cycles
    int m_cnt  = 0;
    int m_hold = 0;
    bit m_run  = 1'b0;
    always @(posedge clk) begin
        if (rst) begin
            m_run = 1'b0; m_cnt = 0; m_hold = 0;
            fim_m <= 1'b0; y_m <= 8'h00;
        end else if (fim_m) begin
            m_hold = m_hold - 1;
            if (m_hold == 0) begin fim_m <= 1'b0; y_m <= 8'hA5; end
        end else begin
            if (!m_run && mult_en) begin m_run = 1'b1; m_cnt = 0; end
            if (m_run) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == lat) begin
                    m_run = 1'b0;
                    m_hold = hold;
                    fim_m <= 1'b1;
                    y_m <= {4'b0, mult_a} * {4'b0, mult_b};
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  req;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  gnt;
        logic [3:0]  ma;
        logic [3:0]  mb;
        logic [7:0]  y;
    } vec_t;

    vec_t vecs [7];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int c = 0;
        while (busy !== 1'b0 && c < 40) begin tick(); c++; end
        chk({nm, "_idle_timeout"}, 32'(c >= 40), 32'd0);
    endtask

    function automatic int oh2idx(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (v[i]) return i;
        return -1;
    endfunction

    // One full transaction from IDLE with a pulse-type done (hold=1)
    task automatic run_txn(input string nm, input vec_t v);
        int c;
        bus.req_i = v.req; bus.a_i = v.a; bus.b_i = v.b;
        tick();
        chk({nm, "_gnt"},  32'(bus.gnt_o), 32'(v.gnt));
        chk({nm, "_ma"},   32'(mult_a),    32'(v.ma));
        chk({nm, "_mb"},   32'(mult_b),    32'(v.mb));
        chk({nm, "_en"},   32'(mult_en),   32'd1);
        chk({nm, "_busy"}, 32'(busy),      32'd1);
        bus.req_i = '0;
        c = 1;
        while (bus.vld_o == 4'd0 && c < 30) begin tick(); c++; end
        chk({nm, "_vld_cycle"}, 32'(c), 32'(lat + 2));
        chk({nm, "_vld"}, 32'(bus.vld_o), 32'(v.gnt));
        chk({nm, "_y"},   32'(bus.y_o),   32'(v.y));
        tick();
        chk({nm, "_busy_after"}, 32'(busy), 32'd0);
        chk({nm, "_vld_after"},  32'(bus.vld_o), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ng, viol, enhi, nv;
        int order [8];
        logic [3:0] prev;
        int vidx [2];
        logic [7:0] vy [2];

        vecs[0] = '{4'b0001, 16'h0003, 16'h0005, 4'b0001, 4'd3,  4'd5,  8'd15};
        vecs[1] = '{4'b0001, 16'h0009, 16'h0009, 4'b0001, 4'd9,  4'd9,  8'd81};
        vecs[2] = '{4'b1000, 16'hF000, 16'h1000, 4'b1000, 4'd15, 4'd1,  8'd15};
        vecs[3] = '{4'b0110, 16'h0740, 16'h0360, 4'b0010, 4'd4,  4'd6,  8'd24};
        vecs[4] = '{4'b0011, 16'h0080, 16'h002C, 4'b0001, 4'd0,  4'd12, 8'd0};
        vecs[5] = '{4'b1100, 16'h1F00, 16'h1F00, 4'b0100, 4'd15, 4'd15, 8'd225};
        vecs[6] = '{4'b0101, 16'h0F02, 16'h0F07, 4'b0001, 4'd2,  4'd7,  8'd14};

        bus.req_i = '0; bus.a_i = '0; bus.b_i = '0;
        fim_force = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        chk("rst_gnt",  32'(bus.gnt_o), 32'd0);
        chk("rst_vld",  32'(bus.vld_o), 32'd0);
        chk("rst_y",    32'(bus.y_o),   32'd0);
        chk("rst_busy", 32'(busy),      32'd0);
        chk("rst_en",   32'(mult_en),   32'd0);
        chk("rst_ma",   32'(mult_a),    32'd0);
        chk("rst_mb",   32'(mult_b),    32'd0);
        rst = 1'b0;
        tick();

        // Directed vectors; expected grants follow the pointer history
        for (int i = 0; i < 7; i++) run_txn($sformatf("vec%0d", i), vecs[i]);

        // Simultaneous requests 0 and 2 held high from ptr=0
        do_reset();
        bus.req_i = 4'b0101; bus.a_i = 16'h0F02; bus.b_i = 16'h0F07;
        c = 0; nv = 0; viol = 0;
        while (nv < 2 && c < 60) begin
            tick(); c++;
            if ($countones(bus.gnt_o) > 1) viol++;
            if (bus.vld_o != 4'd0) begin
                vidx[nv] = oh2idx(bus.vld_o); vy[nv] = bus.y_o; nv++;
                if (nv == 2) bus.req_i = '0;
            end
        end
        chk("simul_count", 32'(nv), 32'd2);
        chk("simul_first_idx",  32'(vidx[0]), 32'd0);
        chk("simul_first_y",    32'(vy[0]),   32'd14);
        chk("simul_second_idx", 32'(vidx[1]), 32'd2);
        chk("simul_second_y",   32'(vy[1]),   32'd225);
        chk("simul_onehot", 32'(viol), 32'd0);
        wait_idle("simul");

        // Fairness: all requesters held high
        do_reset();
        bus.req_i = 4'b1111; bus.a_i = 16'h4321; bus.b_i = 16'h1111;
        ng = 0; c = 0; prev = '0; viol = 0;
        while (ng < 8 && c < 200) begin
            tick(); c++;
            if ($countones(bus.gnt_o) > 1) viol++;
            if (bus.gnt_o != 4'd0 && prev == 4'd0) begin
                order[ng] = oh2idx(bus.gnt_o); ng++;
                if (ng == 8) bus.req_i = '0;
            end
            prev = bus.gnt_o;
        end
        chk("fair_count", 32'(ng), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 4));
        chk("fair_onehot", 32'(viol), 32'd0);
        wait_idle("fair");

        // Level-type done held through DONE and DRAIN
        hold = 4;
        bus.req_i = 4'b0010; bus.a_i = 16'h0050; bus.b_i = 16'h0050;
        tick();
        chk("lvl_gnt", 32'(bus.gnt_o), 32'b0010);
        c = 1;
        while (bus.vld_o == 4'd0 && c < 30) begin tick(); c++; end
        chk("lvl_vld_cycle", 32'(c), 32'd7);
        chk("lvl_y", 32'(bus.y_o), 32'd25);
        tick();
        chk("lvl_drain_busy", 32'(busy), 32'd1);
        chk("lvl_drain_gnt",  32'(bus.gnt_o), 32'd0);
        enhi = 32'(mult_en);
        for (int i = 0; i < 3; i++) begin tick(); enhi += 32'(mult_en); end
        chk("lvl_no_early_en", 32'(enhi), 32'd0);
        tick();
        chk("lvl_restart_en",  32'(mult_en), 32'd1);
        chk("lvl_restart_gnt", 32'(bus.gnt_o), 32'b0010);
        bus.req_i = '0;
        wait_idle("lvl");
        hold = 1;

        // Reset during ARB_WAIT
        bus.req_i = 4'b0100; bus.a_i = 16'h0900; bus.b_i = 16'h0900;
        tick();
        bus.req_i = '0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_gnt",  32'(bus.gnt_o), 32'd0);
        chk("midrst_vld",  32'(bus.vld_o), 32'd0);
        chk("midrst_y",    32'(bus.y_o),   32'd0);
        chk("midrst_busy", 32'(busy),      32'd0);
        chk("midrst_en",   32'(mult_en),   32'd0);
        chk("midrst_ma",   32'(mult_a),    32'd0);
        chk("midrst_mb",   32'(mult_b),    32'd0);
        nv = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (bus.vld_o != 4'd0) nv++; end
        chk("midrst_no_vld", 32'(nv), 32'd0);
        run_txn("midrst_ptr0", '{4'b1010, 16'h2060, 16'h2070, 4'b0010, 4'd6, 4'd7, 8'd42});

        // Spurious done in IDLE/START, then operands changed after grant
        fim_force = 1'b1;
        tick();
        chk("spur_idle_busy", 32'(busy), 32'd0);
        bus.req_i = 4'b0001; bus.a_i = 16'h000B; bus.b_i = 16'h0003;
        tick();
        chk("opchg_gnt", 32'(bus.gnt_o), 32'b0001);
        bus.req_i = '0;
        tick();
        fim_force = 1'b0;
        bus.a_i = 16'hFFFF; bus.b_i = 16'hFFFF;
        tick();
        chk("opchg_ma", 32'(mult_a), 32'd11);
        chk("opchg_mb", 32'(mult_b), 32'd3);
        c = 3;
        while (bus.vld_o == 4'd0 && c < 30) begin tick(); c++; end
        chk("opchg_vld_cycle", 32'(c), 32'd7);
        chk("opchg_y", 32'(bus.y_o), 32'd33);
        wait_idle("opchg");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_arbiter.md
# mult_arbiter

Round-robin arbiter that shares one 4x4 shift-add multiplier datapath among N_REQ requesters. It accepts per-requester multiply requests and latches the winner's operands. It sequences the multiplier's start/done handshake and returns the 8-bit product to the winner with a one-cycle valid pulse. It sits between the processing units and the single multiplier instance. It is a pure scheduler and performs no arithmetic.

## Interface
- N_REQ, 4, number of requesters (2..8)
- W_OP, 4, operand width; product width is 2*W_OP
- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- req_i  in  N_REQ  request per requester
- a_i  in  N_REQ*W_OP  operand A, requester k at bits [k*W_OP +: W_OP]
- b_i  in  N_REQ*W_OP  operand B, same packing
- gnt_o  out  N_REQ  one-hot grant, high for the whole transaction
- vld_o  out  N_REQ  one-cycle result-valid pulse to the granted requester
- y_o  out  2*W_OP  product, valid only while some vld_o bit is high
- busy_o  out  1  high in every state except ARB_IDLE
- mult_en_o  out  1  multiplier start/enable
- mult_a_o, mult_b_o  out  W_OP  latched operands to the multiplier
- mult_y_i  in  2*W_OP  multiplier product
- mult_fim_i  in  1  multiplier done flag

## Operation
- FSM states and transitions:
  - ARB_IDLE → ARB_START when any req_i bit is high.
  - ARB_START → ARB_WAIT, unconditionally.
  - ARB_WAIT → ARB_DONE when mult_fim_i = 1.
  - ARB_DONE → ARB_DRAIN if mult_fim_i = 1; otherwise ARB_DONE → ARB_IDLE.
  - ARB_DRAIN → ARB_IDLE when mult_fim_i = 0.
- Arbitration in ARB_IDLE:
  - Winner is the first requester with req_i high, scanning ptr, ptr+1, … mod N_REQ.
  - On the ARB_IDLE→ARB_START edge the block registers the winner (gnt_o), a_i/b_i slices (mult_a_o/mult_b_o), and sets ptr = winner+1 mod N_REQ.
- Multiplier handshake:
  - mult_en_o is high in ARB_START and ARB_WAIT, low otherwise.
  - In ARB_WAIT, the cycle mult_fim_i=1 is seen, mult_y_i is captured into the result register.
- Result delivery: in ARB_DONE, vld_o[winner]=1 and y_o = captured product; gnt_o drops on exit from ARB_DONE.
- ARB_DRAIN guarantees the multiplier has returned to idle (done flag low) before any new start, so the block works whether done is a pulse or a level.
- Operands are latched at grant. Requester changes to a_i/b_i or req_i after grant do not affect the transaction.
- A req_i still high after its vld_o pulse is a new request. It competes normally with the pointer already advanced past it.
- Width rule: y_o = mult_y_i exactly, with no truncation (2*W_OP bits).

## Timing
- Reset state: ARB_IDLE, ptr=0, and all outputs 0 (gnt_o, vld_o, y_o, busy_o, mult_en_o, mult_a_o, mult_b_o).
- Cycle numbering: req sampled in ARB_IDLE at cycle 0; gnt_o, mult_en_o and operands are valid at cycle 1.
- With mult_fim_i first high at cycle 1+L, vld_o pulses at cycle 2+L.
- Back-to-back: the next grant occurs at the earliest one cycle after mult_fim_i is seen low, following ARB_DONE or ARB_DRAIN.
- Reset mid-transaction (any state): next cycle returns to the reset state. No vld_o pulse is issued, mult_en_o is 0, and ptr returns to 0.
- Simultaneous requests: exactly one grant; the others wait in ARB_IDLE with no loss.
- mult_fim_i high while in ARB_IDLE or ARB_START is ignored.

## Structure
- The shared design package gains typedef enum estado_arb_t {ARB_IDLE, ARB_START, ARB_WAIT, ARB_DONE, ARB_DRAIN}, next to estado_mult_t.
- Sub-module rr_picker (parameter N_REQ): combinational; takes req and ptr, returns a one-hot winner and its index.
- State, ptr, operand and result registers live in mult_arbiter.
- Top-level integration connects mult_a_o/mult_b_o/mult_en_o/mult_y_i/mult_fim_i to the multiplier's A_i/B_i/en_i/Y_o/fim_o.

## Test plan
- Single request: req_i=0001, a=3, b=5, multiplier model with L=5 → gnt_o=0001 at cycle 1; vld_o=0001 with y_o=15 at cycle 7; busy_o low at cycle 8.
- Simultaneous requests: req_i=0101 (a0=2,b0=7; a2=15,b2=15) → requester 0 served first (y=14), then requester 2 (y=225). Never two gnt_o bits high at once.
- Fairness: all four req held high over 8 transactions → grant order 0,1,2,3,0,1,2,3.
- Level done: model holds mult_fim_i high for 3 cycles after ARB_DONE → FSM waits in ARB_DRAIN; next mult_en_o only after fim is low.
- Reset mid-op: assert rst_i during ARB_WAIT → all outputs 0 next cycle, no vld_o. After release, a new request from requester 1 is granted with ptr=0 semantics.
- Operand change after grant: a_i altered at cycle 2 → product reflects the operands latched at grant.
